// File: rtl/tdpram_be_pkg.sv
// tdpram_be_pkg: shared word-width default, lane write-enable helper and clear FSM encoding
package tdpram_be_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_LANE_WIDTH = 8;
    localparam int DW             = DEF_LANES * DEF_LANE_WIDTH;

    typedef enum logic {CLEAR, READY} clr_state_e;

    function automatic logic lane_we(input logic acc, input logic we, input logic be);
        return acc & we & be;
    endfunction

endpackage

// File: rtl/tdpram_lane.sv
// tdpram_lane: one lane-wide dual-port array with write-first/read-first return muxing
module tdpram_lane #(
    parameter int AW = 13,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [LW-1:0] din_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic          lost_b,
    input  logic [AW-1:0] addr_b,
    input  logic [LW-1:0] din_b,
    output logic [LW-1:0] dout_a,
    output logic [LW-1:0] dout_b
);

    logic [LW-1:0] mem [0:(1<<AW)-1];
    logic [LW-1:0] dout_a_d, dout_a_q, dout_b_d, dout_b_q;

    // B lost this lane to A on a same-address write, so it reports A's stored data
    always_comb begin
        dout_a_d = !en_a ? dout_a_q : we_a ? din_a : mem[addr_a];
        dout_b_d = !en_b ? dout_b_q : we_b ? din_b : lost_b ? din_a : mem[addr_b];
    end

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule

// File: rtl/tdpram_be.sv
// tdpram_be: true dual-port RAM with lane write enables, collision arbitration and post-reset clear
module tdpram_be
    import tdpram_be_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_a,
    input  logic                          we_a,
    input  logic [LANES-1:0]              byte_en_a,
    input  logic [ADDR_WIDTH-1:0]         addr_a,
    input  logic [LANES*LANE_WIDTH-1:0]   wdata_a,
    output logic [LANES*LANE_WIDTH-1:0]   rdata_a,
    output logic                          rvalid_a,
    input  logic                          en_b,
    input  logic                          we_b,
    input  logic [LANES-1:0]              byte_en_b,
    input  logic [ADDR_WIDTH-1:0]         addr_b,
    input  logic [LANES*LANE_WIDTH-1:0]   wdata_b,
    output logic [LANES*LANE_WIDTH-1:0]   rdata_b,
    output logic                          rvalid_b,
    output logic                          init_busy,
    output logic                          collision
);

    localparam int WW = LANES * LANE_WIDTH;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  collision_q, collision_d;
    logic                  rv_a_q, rv_a_d, rv_b_q, rv_b_d;
    logic                  busy, acc_a, acc_b, same;
    logic [LANES-1:0]      wa, wb_raw, wb, lost_b;
    logic [ADDR_WIDTH-1:0] lane_addr_a;
    logic [WW-1:0]         lane_din_a, q_a, q_b;

    // The clear engine borrows port A: all lanes write zero to word cnt
    always_comb begin
        busy        = state_q == CLEAR;
        acc_a       = en_a & ~busy;
        acc_b       = en_b & ~busy;
        same        = addr_a == addr_b;
        lane_addr_a = busy ? cnt_q : addr_a;
        lane_din_a  = busy ? '0 : wdata_a;
        for (int i = 0; i < LANES; i++) begin
            wa[i]     = busy | lane_we(acc_a, we_a, byte_en_a[i]);
            wb_raw[i] = lane_we(acc_b, we_b, byte_en_b[i]);
            lost_b[i] = wb_raw[i] & wa[i] & same;
            wb[i]     = wb_raw[i] & ~lost_b[i];
        end
        collision_d = |lost_b;
        cnt_d       = busy ? cnt_q + ADDR_WIDTH'(1) : cnt_q;
        state_d     = (busy && &cnt_q) ? READY : state_q;
        rv_a_d      = acc_a;
        rv_b_d      = acc_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (INIT_CLEAR != 0) ? CLEAR : READY;
            cnt_q       <= '0;
            collision_q <= 1'b0;
            rv_a_q      <= 1'b0;
            rv_b_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
            rv_a_q      <= rv_a_d;
            rv_b_q      <= rv_b_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tdpram_lane #(.AW(ADDR_WIDTH), .LW(LANE_WIDTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_a   (acc_a),
            .we_a   (wa[i]),
            .addr_a (lane_addr_a),
            .din_a  (lane_din_a[i*LANE_WIDTH +: LANE_WIDTH]),
            .en_b   (acc_b),
            .we_b   (wb[i]),
            .lost_b (lost_b[i]),
            .addr_b (addr_b),
            .din_b  (wdata_b[i*LANE_WIDTH +: LANE_WIDTH]),
            .dout_a (q_a[i*LANE_WIDTH +: LANE_WIDTH]),
            .dout_b (q_b[i*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
        logic          rvalid_a_q, rvalid_b_q;
        always_comb begin
            rdata_a_d = rv_a_q ? q_a : rdata_a_q;
            rdata_b_d = rv_b_q ? q_b : rdata_b_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_a_q  <= '0;
                rdata_b_q  <= '0;
                rvalid_a_q <= 1'b0;
                rvalid_b_q <= 1'b0;
            end else begin
                rdata_a_q  <= rdata_a_d;
                rdata_b_q  <= rdata_b_d;
                rvalid_a_q <= rv_a_q;
                rvalid_b_q <= rv_b_q;
            end
        end
        assign rdata_a  = rdata_a_q;
        assign rdata_b  = rdata_b_q;
        assign rvalid_a = rvalid_a_q;
        assign rvalid_b = rvalid_b_q;
    end else begin : g_noreg
        assign rdata_a  = q_a;
        assign rdata_b  = q_b;
        assign rvalid_a = rv_a_q;
        assign rvalid_b = rv_b_q;
    end

    assign init_busy = busy;
    assign collision = collision_q;

endmodule

// File: tb/tb_tdpram_be.sv
// tb_tdpram_be: scoreboard bench driving a latency-1 and a latency-2 instance with identical stimulus
module tb_tdpram_be;

    localparam int AW = 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [3:0]    byte_en_a = '0, byte_en_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [31:0]   wdata_a = '0, wdata_b = '0;
    logic [31:0]   rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic          rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic          ib0, ib1, col0, col1;

    exp_t          q[4][$];
    logic [31:0]   last[4];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tdpram_be #(.ADDR_WIDTH(AW), .LANES(4), .LANE_WIDTH(8), .OUT_REG(0), .INIT_CLEAR(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .byte_en_a(byte_en_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
        .en_b(en_b), .we_b(we_b), .byte_en_b(byte_en_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
        .init_busy(ib0), .collision(col0)
    );

    tdpram_be #(.ADDR_WIDTH(AW), .LANES(4), .LANE_WIDTH(8), .OUT_REG(1), .INIT_CLEAR(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .byte_en_a(byte_en_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .en_b(en_b), .we_b(we_b), .byte_en_b(byte_en_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .init_busy(ib1), .collision(col1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Ports 0/1 are A/B of the latency-1 instance, 2/3 of the latency-2 instance
    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            n_cmp++;
            if (q[p].size() == 0) begin
                n_bad++;
                $display("FAIL rvalid[%0d]: unexpected rvalid at cycle %0d data %h, nothing outstanding", p, cyc, d);
            end else begin
                e = q[p].pop_front();
                if (d !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL rdata[%0d]: got %h at cycle %0d expected %h at cycle %0d", p, d, cyc, e.data, e.cyc);
                end
            end
            last[p] = d;
        end else begin
            n_cmp++;
            if (d !== last[p]) begin
                n_bad++;
                $display("FAIL hold[%0d]: rdata %h changed without rvalid, expected %h", p, d, last[p]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, rvalid_a0, rdata_a0);
            mon(1, rvalid_b0, rdata_b0);
            mon(2, rvalid_a1, rdata_a1);
            mon(3, rvalid_b1, rdata_b1);
        end else begin
            for (int i = 0; i < 4; i++) last[i] = '0;
        end
    end

    task automatic drv_a(input logic we, input logic [3:0] be, input logic [AW-1:0] ad,
                         input logic [31:0] wd, input logic [31:0] exp);
        exp_t e;
        en_a = 1'b1; we_a = we; byte_en_a = be; addr_a = ad; wdata_a = wd;
        e.data = exp;
        e.cyc = cyc + 1; q[0].push_back(e);
        e.cyc = cyc + 2; q[2].push_back(e);
    endtask

    task automatic drv_b(input logic we, input logic [3:0] be, input logic [AW-1:0] ad,
                         input logic [31:0] wd, input logic [31:0] exp);
        exp_t e;
        en_b = 1'b1; we_b = we; byte_en_b = be; addr_b = ad; wdata_b = wd;
        e.data = exp;
        e.cyc = cyc + 1; q[1].push_back(e);
        e.cyc = cyc + 2; q[3].push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (ib0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic drain_check();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("drain[%0d]", i), 32'(q[i].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'({rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1}), 32'd0);
        chk("rst_rdata", rdata_a0 | rdata_b0 | rdata_a1 | rdata_b1, 32'd0);
        chk("rst_busy", 32'({ib0, ib1}), 32'd3);
        chk("rst_collision", 32'({col0, col1}), 32'd0);

        // Reads of addr 5 during the clear window must be dropped
        rst_n = 1'b1;
        en_a = 1'b1; we_a = 1'b0; addr_a = 4'd5;
        count_busy(n);
        en_a = 1'b0;
        chk("clear_len", 32'(n), 32'd16);
        chk("busy_dut1", 32'(ib1), 32'd0);

        drv_a(1'b0, 4'h0, 4'd5, 32'h0, 32'h00000000); step();
        drv_a(1'b1, 4'hF, 4'd3, 32'h11223344, 32'h11223344); step();
        drv_a(1'b1, 4'b0101, 4'd3, 32'hDEADBEEF, 32'h11AD33EF); step();
        drv_a(1'b0, 4'h0, 4'd3, 32'h0, 32'h11AD33EF); step();
        drv_a(1'b1, 4'h0, 4'd3, 32'hFFFFFFFF, 32'h11AD33EF); step();
        drv_a(1'b1, 4'hF, 4'd1, 32'h000000A1, 32'h000000A1); step();
        drv_a(1'b1, 4'hF, 4'd2, 32'h000000A2, 32'h000000A2); step();
        drv_a(1'b0, 4'h0, 4'd1, 32'h0, 32'h000000A1); step();
        drv_a(1'b0, 4'h0, 4'd2, 32'h0, 32'h000000A2); step();
        repeat (3) step();

        // Overlapping writes to addr 7: A wins lane 1
        drv_a(1'b1, 4'b0011, 4'd7, 32'hAAAAAAAA, 32'h0000AAAA);
        drv_b(1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB, 32'h00BBAA00);
        step();
        chk("collision_pulse", 32'({col0, col1}), 32'd3);
        drv_a(1'b0, 4'h0, 4'd7, 32'h0, 32'h00BBAAAA);
        drv_b(1'b0, 4'h0, 4'd7, 32'h0, 32'h00BBAAAA);
        step();
        chk("collision_end", 32'({col0, col1}), 32'd0);

        drv_a(1'b1, 4'b0001, 4'd8, 32'h11111111, 32'h00000011);
        drv_b(1'b1, 4'b1000, 4'd8, 32'h22222222, 32'h22000000);
        step();
        chk("no_collision_disjoint", 32'({col0, col1}), 32'd0);
        drv_a(1'b0, 4'h0, 4'd8, 32'h0, 32'h22000011); step();

        drv_a(1'b1, 4'hF, 4'd9, 32'h12345678, 32'h12345678); step();
        drv_a(1'b0, 4'h0, 4'd9, 32'h0, 32'h12345678);
        drv_b(1'b1, 4'hF, 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        chk("no_collision_rw", 32'({col0, col1}), 32'd0);
        drv_a(1'b0, 4'h0, 4'd9, 32'h0, 32'hFFFFFFFF);
        drv_b(1'b0, 4'h0, 4'd3, 32'h0, 32'h11AD33EF);
        step();
        drain_check();

        // Reset ten cycles into a clear must restart the full sweep
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_mid_clear", 32'(ib0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("busy_in_reset", 32'({ib0, ib1}), 32'd3);
        rst_n = 1'b1;
        count_busy(n);
        chk("clear_restart_len", 32'(n), 32'd16);
        drv_a(1'b0, 4'h0, 4'd3, 32'h0, 32'h00000000); step();
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdpram_be.md
Name: tdpram_be

Overview:
- Parametrised true dual-port RAM with byte-lane (generalised lane) write enables; successor to the fixed 32-bit, 4×8-bit-lane dual-port RAM.
- Adds:
  - configurable lane count and lane width;
  - optional output pipeline register;
  - per-port enable with read-valid tracking;
  - deterministic same-address collision arbitration;
  - post-reset memory-clear engine.
- Serves as the tightly-coupled instruction/data memory behind the core's dual-port local memory interface.

Parameters:
- ADDR_WIDTH, 13, word address width; depth = 2**ADDR_WIDTH words.
- LANES, 4, number of independently write-enabled lanes per word.
- LANE_WIDTH, 8, bits per lane; word width DW = LANES*LANE_WIDTH.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2.
- INIT_CLEAR, 1, 1 = zero all words after reset before accepting accesses; 0 = no clear.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en_a  in  1  port A access request.
- we_a  in  1  port A write (qualified by en_a).
- byte_en_a  in  LANES  port A lane write enables.
- addr_a  in  ADDR_WIDTH  port A word address.
- wdata_a  in  DW  port A write data.
- rdata_a  out  DW  port A read data.
- rvalid_a  out  1  rdata_a valid this cycle.
- en_b, we_b, byte_en_b, addr_b, wdata_b, rdata_b, rvalid_b: port B, identical to port A.
- init_busy  out  1  clear engine running; accesses ignored.
- collision  out  1  one-cycle pulse: overlapping same-address writes occurred.

Behaviour:
- Reset values (async, rst_n=0): rdata_a/b=0, rvalid_a/b=0, collision=0, init_busy=INIT_CLEAR, clear counter=0. Memory array is not reset.
- Clear FSM, states CLEAR and READY:
  - Reset enters CLEAR if INIT_CLEAR=1, else READY.
  - CLEAR writes all-zero to word cnt each cycle, then cnt++. At cnt = 2**ADDR_WIDTH-1, that word is written and the FSM goes to READY.
  - Total clear time is exactly 2**ADDR_WIDTH cycles after reset release.
  - Reset asserted mid-clear restarts at cnt=0.
  - READY is terminal until the next reset.
- Acceptance: an access on port X is accepted when en_x=1 and init_busy=0. Requests made during CLEAR are dropped: no write, no rvalid.
- Latency: rvalid_x asserts exactly 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after every accepted access, read or write. Fully pipelined, one access per port per cycle. rdata_x holds its last value while rvalid_x=0.
- Effective write enable per lane: we_x & byte_en_x[i]. A write with byte_en=0 is treated as a read.
- Same-port write-first: a write returns the new data on enabled lanes and the prior stored data on disabled lanes.
- Cross-port, same address, both accepted:
  - A reads, B writes (or the reverse): the reader returns the old word (read-first); the writer behaves as write-first.
  - Both write, overlapping lanes: port A wins each overlapping lane. Non-overlapping lanes from each port are written normally.
  - Each port's returned data reflects the final stored word for lanes it wrote and old data for lanes it did not write.
  - collision is registered and pulses in the cycle after overlapping writes.
  - Non-overlapping writes to the same address raise no collision.
- Address wrap: none; the full 2**ADDR_WIDTH space is valid.

Decomposition:
- Shared package: constant DW, lane-mask helper function, clear-FSM state encoding (CLEAR, READY).
- Sub-module tdpram_lane, instantiated LANES times:
  - one LANE_WIDTH-wide dual-port array;
  - per-port write enable;
  - write-first/read-first muxing.
- Top level owns:
  - the clear FSM, with the clear mux onto port A;
  - collision arbitration, which masks B's lane enables where A writes;
  - valid pipeline;
  - OUT_REG stage.

Test Plan:
- Reset release with INIT_CLEAR=1, ADDR_WIDTH=4 → init_busy=1 for exactly 16 cycles. A read of addr 5 issued during that window gives no rvalid. A read after clear returns 0x00000000.
- Write A addr 3 data 0xDEADBEEF byte_en=4'b0101 over stored 0x11223344 → rdata_a next cycle = 0x11AD33EF. A later read of addr 3 returns the same value.
- OUT_REG=1, back-to-back reads of addr 1 then addr 2 (0xA1, 0xA2) → rvalid_a high for 2 consecutive cycles starting 2 cycles after the first request, data in order.
- Same cycle, addr 7: A writes 0xAAAAAAAA be=4'b0011, B writes 0xBBBBBBBB be=4'b0110 → stored 0x00BBAAAA, collision pulses once in the next cycle.
- Same cycle, addr 9 holding 0x12345678: A reads, B writes 0xFFFFFFFF be=4'b1111 → rdata_a=0x12345678, rdata_b=0xFFFFFFFF, collision=0.
- rst_n asserted mid-clear at cnt=10, then released → clear restarts from 0 and init_busy stays high for the full depth.
